hs_ram_arbiter: RTL
===================

# hs_ram_arbiter

Shares the game's work RAM port between the Z80 CPU and the hiscore engine. When the hiscore engine raises a read or write intent, the block pauses the CPU and waits a fixed settle window. It then switches the RAM address/data/write-enable mux to the hiscore side, and returns the RAM to the CPU through a one-cycle release state. It sits in the game core between the CPU bus decode, the work-RAM instance and the hiscore module. It also merges the user/OSD pause into the single CPU pause line.

## Interface
Parameters:
- AW, 16, RAM address width
- SETTLE, 4, cycles pause is held before grant (1..15)
- WDOG_BITS, 16, watchdog counter width (only with HS_ARB_WATCHDOG_EN)

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- pause_user  in  1  pause request from pause/OSD logic
- pause_cpu  out  1  CPU pause/wait line
- hs_read_intent  in  1  hiscore wants to read RAM
- hs_write_intent  in  1  hiscore wants to write RAM
- hs_address  in  AW  hiscore RAM address
- hs_data_in  in  8  hiscore write data
- hs_write_enable  in  1  hiscore write strobe
- hs_data_out  out  8  RAM read data to hiscore
- hs_grant  out  1  RAM currently owned by hiscore
- cpu_addr  in  AW  CPU RAM address
- cpu_dout  in  8  CPU write data
- cpu_wr  in  1  CPU RAM write strobe (already decoded)
- cpu_din  out  8  RAM read data to CPU
- ram_addr  out  AW  RAM address
- ram_din  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  8  RAM read data (synchronous RAM, 1-cycle latency)
- wdog_err  out  1  sticky watchdog flag (tied 0 without HS_ARB_WATCHDOG_EN)

## Operation
- intent = hs_read_intent | hs_write_intent.
- States: IDLE, SETTLE, GRANT, RELEASE.
- IDLE: mux selects CPU. If intent, go to SETTLE and load settle counter with SETTLE-1.
- SETTLE: mux still selects CPU, and cpu_wr still passes so the CPU can complete an in-flight write. Decrement the counter. When the counter is 0, go to GRANT. If intent drops, go to RELEASE.
- GRANT: mux selects hiscore: ram_addr=hs_address, ram_din=hs_data_in, ram_we=hs_write_enable. cpu_wr is blocked. When intent drops, go to RELEASE.
- RELEASE: mux selects CPU with ram_we forced 0 for one cycle, then go to IDLE.
- pause_cpu = pause_user | (state != IDLE); the state term is registered.
- hs_grant = (state == GRANT), registered.
- hs_data_out: register updated from ram_dout on every cycle where the previous cycle was GRANT; holds otherwise.
- cpu_din = ram_dout, unconditionally.
- hs_write_enable outside GRANT is ignored and produces no RAM write.
- pause_user does not shorten SETTLE. The full window always runs.
- Reset, including mid-GRANT: state=IDLE, counter=0, mux returns to CPU.

## Timing
- Reset values: pause_cpu = pause_user (state term 0), hs_grant=0, hs_data_out=0x00, ram_we = cpu_wr (CPU side), wdog_err=0.
- Intent sampled high at edge N: pause_cpu high after edge N.
- hs_grant high after edge N+SETTLE.
- First hiscore write is accepted on the first GRANT cycle.
- Read: the address presented in GRANT cycle k gives hs_data_out valid after edge k+2. The hiscore engine holds the address for at least 2 cycles.
- Intent low at edge M while in GRANT: hs_grant low after M, RELEASE for one cycle, pause_cpu low after M+1 (if pause_user=0).
- Intent reasserted during RELEASE: go to IDLE, then restart SETTLE. No back-to-back grant skips settle.
- Read and write intent together are treated as one intent. Write strobe decides direction per cycle.

## Configuration
- HS_ARB_WATCHDOG_EN defined:
  - A WDOG_BITS counter runs in SETTLE and GRANT and clears in IDLE.
  - On all-ones: force RELEASE, set wdog_err (sticky until reset), and ignore intent until it deasserts for at least one cycle.
- Undefined: no counter, and wdog_err is tied 0.

## Test plan
- Reset mid-GRANT with hs_write_enable=1 -> next cycle hs_grant=0, ram_we follows cpu_wr, pause_cpu=pause_user.
- SETTLE=4, raise hs_write_intent at edge 10, write 0x5A to 0x6000 -> pause_cpu=1 from edge 10, hs_grant=1 from edge 14, RAM[0x6000]=0x5A, and a CPU write attempted at the same time is dropped.
- hs_read_intent with RAM[0x6010]=0xC3 preloaded, address held 2 cycles -> hs_data_out=0xC3 two edges after first GRANT address cycle.
- cpu_wr=1 to 0x6020 in the first SETTLE cycle -> write lands; drop intent in GRANT -> exactly one RELEASE cycle with ram_we=0, then pause_cpu=0.
- pause_user=1 throughout hiscore cycle -> pause_cpu stays 1 after RELEASE; SETTLE still 4 cycles.
- With HS_ARB_WATCHDOG_EN, WDOG_BITS=4, intent held 20 cycles -> forced RELEASE at counter 15, wdog_err=1, no re-grant until intent drops.

Source files
------------

// File: rtl/hs_ram_arbiter.sv
// Arbitrates the game work-RAM port between the Z80 and the hiscore engine.
// Optional watchdog enabled by defining HS_ARB_WATCHDOG_EN.
module hs_ram_arbiter #(
  parameter int AW        = 16,
  parameter int SETTLE    = 4,
  parameter int WDOG_BITS = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          pause_user,
  output logic          pause_cpu,
  input  logic          hs_read_intent,
  input  logic          hs_write_intent,
  input  logic [AW-1:0] hs_address,
  input  logic [7:0]    hs_data_in,
  input  logic          hs_write_enable,
  output logic [7:0]    hs_data_out,
  output logic          hs_grant,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_wr,
  output logic [7:0]    cpu_din,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic          wdog_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  if (SETTLE < 1 || SETTLE > 15 || WDOG_BITS < 2) begin : g_bad_params
    $error("hs_ram_arbiter: SETTLE must be 1..15 and WDOG_BITS at least 2");
  end

  state_t     state_reg, state_next;
  logic [3:0] settle_cnt_reg, settle_cnt_next;
  logic       prev_grant_reg;
  logic [7:0] hs_data_reg;
  logic       intent;
  logic       intent_eff;
  logic       wdog_trip;

  assign intent = hs_read_intent | hs_write_intent;

`ifdef HS_ARB_WATCHDOG_EN
  logic [WDOG_BITS-1:0] wdog_cnt_reg;
  logic                 wdog_err_reg;
  logic                 wdog_block_reg;

  assign wdog_trip  = ((state_reg == ST_SETTLE) || (state_reg == ST_GRANT)) && (&wdog_cnt_reg);
  // After a trip the engine must drop intent for a cycle before it can win again.
  assign intent_eff = intent & ~wdog_block_reg;
  assign wdog_err   = wdog_err_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wdog_cnt_reg   <= '0;
      wdog_err_reg   <= 1'b0;
      wdog_block_reg <= 1'b0;
    end else begin
      if ((state_reg == ST_SETTLE) || (state_reg == ST_GRANT))
        wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
      else
        wdog_cnt_reg <= '0;
      if (wdog_trip) begin
        wdog_err_reg   <= 1'b1;
        wdog_block_reg <= 1'b1;
      end else if (!intent) begin
        wdog_block_reg <= 1'b0;
      end
    end
  end
`else
  assign wdog_trip  = 1'b0;
  assign intent_eff = intent;
  assign wdog_err   = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      prev_grant_reg <= 1'b0;
      hs_data_reg    <= 8'h00;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      prev_grant_reg <= (state_reg == ST_GRANT);
      // RAM has one cycle of read latency, so capture one cycle after GRANT.
      if (prev_grant_reg)
        hs_data_reg <= ram_dout;
    end
  end

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (intent_eff) begin
          state_next      = ST_SETTLE;
          settle_cnt_next = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (wdog_trip || !intent_eff)
          state_next = ST_RELEASE;
        else if (settle_cnt_reg == 4'd0)
          state_next = ST_GRANT;
        else
          settle_cnt_next = settle_cnt_reg - 4'd1;
      end
      ST_GRANT: begin
        if (wdog_trip || !intent_eff)
          state_next = ST_RELEASE;
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // SETTLE keeps the CPU on the port so an in-flight write can still land.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = cpu_wr;
    case (state_reg)
      ST_GRANT: begin
        ram_addr = hs_address;
        ram_din  = hs_data_in;
        ram_we   = hs_write_enable;
      end
      ST_RELEASE: ram_we = 1'b0;
      default: ;
    endcase
  end

  assign pause_cpu   = pause_user | (state_reg != ST_IDLE);
  assign hs_grant    = (state_reg == ST_GRANT);
  assign hs_data_out = hs_data_reg;
  assign cpu_din     = ram_dout;

endmodule
